// File: rtl/burst_write_ctrl_if.sv
// Request/status bundle between a burst write controller and the FIFO write side it feeds.
// master is the controller; slave is whoever issues bursts and owns the FIFO flag.
interface burst_write_ctrl_if #(
    parameter int unsigned DATASIZE = 9
);
    logic                start;
    logic [10:0]         burst_len;
    logic [DATASIZE-1:0] data_seed;
    logic                wfull;
    logic                winc;
    logic [DATASIZE-1:0] wdata;
    logic                busy;
    logic                done;
    logic [10:0]         words_sent;
    logic [15:0]         stall_cycles;

    modport master (
        input  start, burst_len, data_seed, wfull,
        output winc, wdata, busy, done, words_sent, stall_cycles
    );

    modport slave (
        output start, burst_len, data_seed, wfull,
        input  winc, wdata, busy, done, words_sent, stall_cycles
    );
endinterface

// File: rtl/burst_write_ctrl.sv
// Writes an incrementing data burst into a FIFO, pacing writes with idle gaps
// and counting cycles lost to back-pressure from wfull.
module burst_write_ctrl #(
    parameter int unsigned DATASIZE     = 9,
    parameter int unsigned BURST_LENGTH = 1024,
    parameter int unsigned WRITE_PERIOD = 2
) (
    input  logic               wclk,
    input  logic               wrst_n,
    burst_write_ctrl_if.master bus
);

    localparam int unsigned     GapW    = (WRITE_PERIOD > 1) ? $clog2(WRITE_PERIOD) : 1;
    localparam logic [10:0]     MaxLen  = 11'(BURST_LENGTH);
    localparam logic [GapW-1:0] GapLast = GapW'((WRITE_PERIOD > 0) ? WRITE_PERIOD - 1 : 0);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StGap,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [10:0]         len_q, len_d;
    logic [DATASIZE-1:0] word_q, word_d;
    logic [10:0]         words_q, words_d;
    logic [15:0]         stall_q, stall_d;
    logic [GapW-1:0]     gap_q, gap_d;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= StIdle;
            len_q   <= '0;
            word_q  <= '0;
            words_q <= '0;
            stall_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            word_q  <= word_d;
            words_q <= words_d;
            stall_q <= stall_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        word_d  = word_q;
        words_d = words_q;
        stall_d = stall_q;
        gap_d   = gap_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    words_d = '0;
                    stall_d = '0;
                    word_d  = bus.data_seed;
                    if (bus.burst_len == 11'd0) begin
                        len_d   = '0;
                        state_d = StDone;
                    end else begin
                        len_d   = (bus.burst_len > MaxLen) ? MaxLen : bus.burst_len;
                        state_d = StWrite;
                    end
                end
            end

            StWrite: begin
                if (bus.wfull) begin
                    if (stall_q != 16'hFFFF) begin
                        stall_d = stall_q + 16'd1;
                    end
                end else begin
                    words_d = words_q + 11'd1;
                    word_d  = word_q + 1'b1;
                    if (words_d == len_q) begin
                        state_d = StDone;
                    end else if (WRITE_PERIOD == 0) begin
                        state_d = StWrite;
                    end else begin
                        gap_d   = '0;
                        state_d = StGap;
                    end
                end
            end

            // wfull is deliberately not looked at here; the gap is pure pacing.
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StWrite;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.winc         = (state_q == StWrite) && !bus.wfull;
    assign bus.wdata        = word_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = (state_q == StDone);
    assign bus.words_sent   = words_q;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_burst_write_ctrl.sv
// Directed bench for burst_write_ctrl: cycle k is observed at the k-th falling edge after start.
module tb_burst_write_ctrl;

    localparam int unsigned DW = 9;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 wclk = ~wclk;

    burst_write_ctrl_if #(.DATASIZE(DW)) bus ();

    burst_write_ctrl #(
        .DATASIZE    (DW),
        .BURST_LENGTH(1024),
        .WRITE_PERIOD(2)
    ) dut (
        .wclk  (wclk),
        .wrst_n(wrst_n),
        .bus   (bus)
    );

    // Presents start for exactly one rising edge; returns at the sample point of cycle 1.
    task automatic kick(input logic [10:0] len, input logic [DW-1:0] seed);
        @(negedge wclk);
        bus.start     = 1'b1;
        bus.burst_len = len;
        bus.data_seed = seed;
        @(negedge wclk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge wclk);
        checks++;
        if (bus.winc !== 1'b0) begin errors++; $display("FAIL reset_winc got %b want 0", bus.winc); end
        checks++;
        if (bus.wdata !== 9'h000) begin errors++; $display("FAIL reset_wdata got %h want 000", bus.wdata); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++;
        if (bus.words_sent !== 11'd0) begin errors++; $display("FAIL reset_words got %0d want 0", bus.words_sent); end
        checks++;
        if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", bus.stall_cycles); end
        wrst_n = 1'b1;
        @(negedge wclk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_basic();
        logic          exp_winc;
        logic          exp_done;
        logic [DW-1:0] exp_data;
        bus.wfull = 1'b0;
        kick(11'd4, 9'h010);
        exp_data = 9'h010;
        for (int k = 1; k <= 12; k++) begin
            exp_winc = (k == 1) || (k == 4) || (k == 7) || (k == 10);
            exp_done = (k == 11);
            checks++;
            if (bus.winc !== exp_winc) begin
                errors++; $display("FAIL basic_winc cycle %0d got %b want %b", k, bus.winc, exp_winc);
            end
            if (exp_winc) begin
                checks++;
                if (bus.wdata !== exp_data) begin
                    errors++; $display("FAIL basic_wdata cycle %0d got %h want %h", k, bus.wdata, exp_data);
                end
                exp_data = exp_data + 1'b1;
            end
            checks++;
            if (bus.done !== exp_done) begin
                errors++; $display("FAIL basic_done cycle %0d got %b want %b", k, bus.done, exp_done);
            end
            @(negedge wclk);
        end
        checks++;
        if (bus.words_sent !== 11'd4) begin errors++; $display("FAIL basic_words got %0d want 4", bus.words_sent); end
        checks++;
        if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL basic_stall got %0d want 0", bus.stall_cycles); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] want [3];
        int            n;
        bit            seen_done;
        want[0] = 9'h1FE; want[1] = 9'h1FF; want[2] = 9'h000;
        n = 0;
        seen_done = 1'b0;
        kick(11'd3, 9'h1FE);
        for (int k = 1; k <= 20 && !seen_done; k++) begin
            if (bus.winc === 1'b1) begin
                checks++;
                if (n >= 3) begin
                    errors++; $display("FAIL wrap_extra_write got write %0d want 3 writes", n + 1);
                end else if (bus.wdata !== want[n]) begin
                    errors++; $display("FAIL wrap_wdata write %0d got %h want %h", n, bus.wdata, want[n]);
                end
                n++;
            end
            if (bus.done === 1'b1) seen_done = 1'b1;
            @(negedge wclk);
        end
        checks++;
        if (!seen_done) begin errors++; $display("FAIL wrap_done got none want pulse"); end
        checks++;
        if (n != 3) begin errors++; $display("FAIL wrap_count got %0d want 3", n); end
    endtask

    task automatic test_stall();
        logic          exp_winc;
        logic          exp_done;
        logic [DW-1:0] exp_data;
        bus.wfull = 1'b1;
        kick(11'd2, 9'h055);
        exp_data = 9'h055;
        for (int k = 1; k <= 11; k++) begin
            // high through the first five WRITE cycles, then a blip during GAP
            bus.wfull = (k <= 5) || (k == 7);
            #1;
            exp_winc = (k == 6) || (k == 9);
            exp_done = (k == 10);
            checks++;
            if (bus.winc !== exp_winc) begin
                errors++; $display("FAIL stall_winc cycle %0d got %b want %b", k, bus.winc, exp_winc);
            end
            if (exp_winc) begin
                checks++;
                if (bus.wdata !== exp_data) begin
                    errors++; $display("FAIL stall_wdata cycle %0d got %h want %h", k, bus.wdata, exp_data);
                end
                exp_data = exp_data + 1'b1;
            end
            checks++;
            if (bus.done !== exp_done) begin
                errors++; $display("FAIL stall_done cycle %0d got %b want %b", k, bus.done, exp_done);
            end
            @(negedge wclk);
        end
        bus.wfull = 1'b0;
        checks++;
        if (bus.stall_cycles !== 16'd5) begin errors++; $display("FAIL stall_count got %0d want 5", bus.stall_cycles); end
        checks++;
        if (bus.words_sent !== 11'd2) begin errors++; $display("FAIL stall_words got %0d want 2", bus.words_sent); end
    endtask

    task automatic test_zero_len();
        kick(11'd0, 9'h033);
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", bus.done); end
        checks++;
        if (bus.winc !== 1'b0) begin errors++; $display("FAIL zero_winc got %b want 0", bus.winc); end
        @(negedge wclk);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_done_len got %b want 0", bus.done); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b want 0", bus.busy); end
        checks++;
        if (bus.words_sent !== 11'd0) begin errors++; $display("FAIL zero_words got %0d want 0", bus.words_sent); end
        checks++;
        if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL zero_stall got %0d want 0", bus.stall_cycles); end
    endtask

    task automatic test_clamp();
        int            n;
        int            bad;
        bit            seen_done;
        logic [DW-1:0] exp_data;
        n = 0;
        bad = 0;
        seen_done = 1'b0;
        exp_data = 9'h000;
        kick(11'd2000, 9'h000);
        for (int k = 1; k <= 3200 && !seen_done; k++) begin
            if (bus.winc === 1'b1) begin
                if (bus.wdata !== exp_data) bad++;
                exp_data = exp_data + 1'b1;
                n++;
            end
            if (bus.done === 1'b1) seen_done = 1'b1;
            @(negedge wclk);
        end
        checks++;
        if (!seen_done) begin errors++; $display("FAIL clamp_done got none want pulse within 3200 cycles"); end
        checks++;
        if (n != 1024) begin errors++; $display("FAIL clamp_count got %0d want 1024", n); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL clamp_wdata got %0d wrong words want 0", bad); end
        checks++;
        if (bus.words_sent !== 11'd1024) begin
            errors++; $display("FAIL clamp_words got %0d want 1024", bus.words_sent);
        end
    endtask

    task automatic test_reset_mid();
        kick(11'd8, 9'h020);
        repeat (9) @(negedge wclk);
        // cycle 10: fourth write is being offered
        checks++;
        if (bus.winc !== 1'b1) begin errors++; $display("FAIL rmid_pre_winc got %b want 1", bus.winc); end
        checks++;
        if (bus.words_sent !== 11'd3) begin errors++; $display("FAIL rmid_pre_words got %0d want 3", bus.words_sent); end
        wrst_n = 1'b0;
        #1;
        checks++;
        if (bus.winc !== 1'b0) begin errors++; $display("FAIL rmid_winc got %b want 0", bus.winc); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
        checks++;
        if (bus.words_sent !== 11'd0) begin errors++; $display("FAIL rmid_words got %0d want 0", bus.words_sent); end
        checks++;
        if (bus.wdata !== 9'h000) begin errors++; $display("FAIL rmid_wdata got %h want 000", bus.wdata); end
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge wclk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL rmid_idle cycle %0d got done=%b busy=%b want 0 0", k, bus.done, bus.busy);
            end
        end
        kick(11'd1, 9'h077);
        checks++;
        if (bus.winc !== 1'b1 || bus.wdata !== 9'h077) begin
            errors++; $display("FAIL rmid_restart got winc=%b wdata=%h want 1 077", bus.winc, bus.wdata);
        end
        @(negedge wclk);
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL rmid_restart_done got %b want 1", bus.done); end
        @(negedge wclk);
        checks++;
        if (bus.words_sent !== 11'd1) begin errors++; $display("FAIL rmid_restart_words got %0d want 1", bus.words_sent); end
    endtask

    task automatic test_ignore_start();
        logic          exp_winc;
        logic          exp_busy;
        logic [DW-1:0] exp_data;
        kick(11'd3, 9'h100);
        exp_data = 9'h100;
        for (int k = 1; k <= 10; k++) begin
            if (k == 2 || k == 4) begin
                bus.start     = 1'b1;
                bus.burst_len = 11'd7;
                bus.data_seed = 9'h0AA;
            end else begin
                bus.start = 1'b0;
            end
            #1;
            exp_winc = (k == 1) || (k == 4) || (k == 7);
            exp_busy = (k <= 8);
            checks++;
            if (bus.winc !== exp_winc) begin
                errors++; $display("FAIL ign_winc cycle %0d got %b want %b", k, bus.winc, exp_winc);
            end
            if (exp_winc) begin
                checks++;
                if (bus.wdata !== exp_data) begin
                    errors++; $display("FAIL ign_wdata cycle %0d got %h want %h", k, bus.wdata, exp_data);
                end
                exp_data = exp_data + 1'b1;
            end
            checks++;
            if (bus.busy !== exp_busy) begin
                errors++; $display("FAIL ign_busy cycle %0d got %b want %b", k, bus.busy, exp_busy);
            end
            @(negedge wclk);
        end
        bus.start = 1'b0;
        checks++;
        if (bus.words_sent !== 11'd3) begin errors++; $display("FAIL ign_words got %0d want 3", bus.words_sent); end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.burst_len = 11'd0;
        bus.data_seed = '0;
        bus.wfull     = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_len();
        test_clamp();
        test_reset_mid();
        test_ignore_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
